// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: bitwise logic unit feeding a DEPTH-entry result FIFO.
// Operands are accepted with a valid/ready handshake, the result of the selected op is
// written into the FIFO, and the head entry is presented with its own valid/ready handshake.
// Optional feature macro: LOGIC_REDUCE_EN adds out_flags = {^r, |r, &r} stored with each result.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
`ifdef LOGIC_REDUCE_EN
    output logic [2:0]               out_flags,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
    localparam logic [CntW-1:0] CntZero = '0;
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] result;
    logic             push, pop;

`ifdef LOGIC_REDUCE_EN
    logic [2:0] flag_mem_q [DEPTH];
    logic [2:0] out_flags_q, out_flags_d;
    logic [2:0] result_flags;
`endif

    // Handshakes depend on registered state only; full/empty come straight from count_q.
    assign in_ready  = (count_q != CntFull);
    assign out_valid = (count_q != CntZero);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_data_q;
    assign count     = count_q;

    // Bitwise operation decode.
    always_comb begin
        result = '0;
        case (op)
            3'b000:  result = a & b;
            3'b001:  result = a | b;
            3'b010:  result = ~a;
            3'b011:  result = ~(a & b);
            3'b100:  result = ~(a | b);
            3'b101:  result = a ^ b;
            3'b110:  result = ~(a ^ b);
            default: result = a;
        endcase
    end

`ifdef LOGIC_REDUCE_EN
    assign result_flags = {^result, |result, &result};
    assign out_flags    = out_flags_q;
`endif

    // Pointer/count update and selection of the next head entry.
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
        count_d    = count_q;
        out_data_d = out_data_q;
`ifdef LOGIC_REDUCE_EN
        out_flags_d = out_flags_q;
`endif
        if (push && !pop) begin
            count_d = count_q + CntOne;
        end else if (!push && pop) begin
            count_d = count_q - CntOne;
        end
        // The output register preloads the next head; when the FIFO drains it keeps its
        // last value. If the incoming result becomes the head, bypass the memory.
        if (count_d != CntZero) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                out_data_d = result;
`ifdef LOGIC_REDUCE_EN
                out_flags_d = result_flags;
`endif
            end else begin
                out_data_d = mem_q[rd_ptr_d];
`ifdef LOGIC_REDUCE_EN
                out_flags_d = flag_mem_q[rd_ptr_d];
`endif
            end
        end
    end

    // Control and output registers; async reset discards everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
`ifdef LOGIC_REDUCE_EN
            out_flags_q <= '0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
`ifdef LOGIC_REDUCE_EN
            out_flags_q <= out_flags_d;
`endif
        end
    end

    // Result storage; contents are only visible through the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= result;
`ifdef LOGIC_REDUCE_EN
            flag_mem_q[wr_ptr_q] <= result_flags;
`endif
        end
    end

endmodule
